// File: rtl/complex_result_accumulator.sv
// Accumulates ACC_LEN complex multiplier results into one complex sum, presented on a valid/ready port.
// Optional feature: define COMPLEX_ACC_SAT_EN for per-component saturating accumulation with a sticky acc_sat flag.
module complex_result_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_LEN    = 4,
    parameter int GUARD_BITS = 4,
    localparam int ACC_W     = 2 * DATA_WIDTH + GUARD_BITS
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    res_val,
    output logic                    res_ready,
    input  logic [2*DATA_WIDTH-1:0] result_re,
    input  logic [2*DATA_WIDTH-1:0] result_im,
    output logic                    acc_val,
    input  logic                    acc_ready,
    output logic [ACC_W-1:0]        acc_re,
    output logic [ACC_W-1:0]        acc_im,
    output logic                    acc_sat
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic signed [ACC_W-1:0]   sum_re;
    logic signed [ACC_W-1:0]   sum_im;
    logic signed [ACC_W-1:0]   beat_re;
    logic signed [ACC_W-1:0]   beat_im;
    logic signed [ACC_W-1:0]   nxt_re;
    logic signed [ACC_W-1:0]   nxt_im;
    logic                      beat_xfer;

    // Ready is a pure function of state and sw_rst so the upstream sees no combinational loop.
    assign res_ready = (state == ACCUM) && !sw_rst;
    assign acc_val   = (state == HOLD);
    assign beat_xfer = res_val && res_ready;

    assign beat_re = ACC_W'($signed(result_re));
    assign beat_im = ACC_W'($signed(result_im));

    assign acc_re = sum_re;
    assign acc_im = sum_im;

`ifdef COMPLEX_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] ext_re;
    logic signed [ACC_W:0] ext_im;
    logic                  nxt_clamp;
    logic                  sat_q;

    function automatic logic signed [ACC_W:0] add_ext(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
        return (ACC_W+1)'(a) + (ACC_W+1)'(b);
    endfunction

    function automatic logic ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] ^ s[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
        if (ovf(s))
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    always_comb begin
        ext_re    = add_ext(sum_re, beat_re);
        ext_im    = add_ext(sum_im, beat_im);
        nxt_re    = sat_acc(ext_re);
        nxt_im    = sat_acc(ext_im);
        nxt_clamp = ovf(ext_re) || ovf(ext_im);
    end

    // Sticky for the frame: cleared whenever the sum is consumed or discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            sat_q <= 1'b0;
        else if (sw_rst || (state == CLEAR) || ((state == HOLD) && acc_ready))
            sat_q <= 1'b0;
        else if (beat_xfer && nxt_clamp)
            sat_q <= 1'b1;
    end

    assign acc_sat = sat_q;
`else
    assign nxt_re  = sum_re + beat_re;
    assign nxt_im  = sum_im + beat_im;
    assign acc_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CLEAR;
            beat_cnt <= '0;
            sum_re   <= '0;
            sum_im   <= '0;
        end else if (sw_rst) begin
            state    <= CLEAR;
            beat_cnt <= '0;
            sum_re   <= '0;
            sum_im   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    state    <= ACCUM;
                    beat_cnt <= '0;
                    sum_re   <= '0;
                    sum_im   <= '0;
                end
                ACCUM: begin
                    if (beat_xfer) begin
                        sum_re <= nxt_re;
                        sum_im <= nxt_im;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= '0;
                            state    <= HOLD;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        sum_re <= '0;
                        sum_im <= '0;
                        state  <= ACCUM;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Bench for complex_result_accumulator: directed scenarios plus randomized frames against an integer model.
module tb_complex_result_accumulator;

    localparam int DW = 8;
    localparam int AL = 4;
    localparam int AW = 2 * DW + 4;
    localparam int OW = 2 * DW;
`ifdef COMPLEX_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn, sw_rst, res_val, res_ready, acc_val, acc_ready, acc_sat;
    logic [2*DW-1:0] result_re, result_im;
    logic [AW-1:0]   acc_re, acc_im;

    logic o_sw_rst, o_res_val, o_res_ready, o_acc_val, o_acc_ready, o_acc_sat;
    logic [2*DW-1:0] o_result_re, o_result_im;
    logic [OW-1:0]   o_acc_re, o_acc_im;

    int checks = 0;
    int passed = 0;
    longint m_re, m_im;
    bit m_sat;

    always #5 clk = ~clk;

    complex_result_accumulator #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(4)) dut (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .res_val(res_val), .res_ready(res_ready),
        .result_re(result_re), .result_im(result_im), .acc_val(acc_val), .acc_ready(acc_ready),
        .acc_re(acc_re), .acc_im(acc_im), .acc_sat(acc_sat)
    );

    complex_result_accumulator #(.DATA_WIDTH(DW), .ACC_LEN(AL), .GUARD_BITS(0)) dut_ovf (
        .clk(clk), .rstn(rstn), .sw_rst(o_sw_rst), .res_val(o_res_val), .res_ready(o_res_ready),
        .result_re(o_result_re), .result_im(o_result_im), .acc_val(o_acc_val), .acc_ready(o_acc_ready),
        .acc_re(o_acc_re), .acc_im(o_acc_im), .acc_sat(o_acc_sat)
    );

    function automatic longint sx(input logic [AW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: one addition into a w-bit two's-complement accumulator, wrapping or clamping.
    function automatic longint model_add(input longint s, input longint x, input int w, output bit clamped);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        longint v  = s + x;
        clamped = 1'b0;
        if (SAT_EN) begin
            if (v > hi) begin v = hi; clamped = 1'b1; end
            else if (v < lo) begin v = lo; clamped = 1'b1; end
        end else begin
            while (v > hi) v -= (longint'(1) <<< w);
            while (v < lo) v += (longint'(1) <<< w);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_re = 0; m_im = 0; m_sat = 1'b0;
    endtask

    task automatic send_beat(input int re, input int im, output int waits);
        bit ok = 1'b0;
        bit c1, c2;
        result_re = (2*DW)'(re);
        result_im = (2*DW)'(im);
        res_val   = 1'b1;
        waits     = 0;
        for (int w = 0; w < 20; w++) begin
            if (res_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
            waits++;
        end
        res_val = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL send_beat_timeout: res_ready never rose within 20 cycles");
        end else begin
            m_re  = model_add(m_re, longint'(re), AW, c1);
            m_im  = model_add(m_im, longint'(im), AW, c2);
            m_sat = m_sat | c1 | c2;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; sw_rst = 1'b0; res_val = 1'b0; acc_ready = 1'b0;
        result_re = '0; result_im = '0;
        o_sw_rst = 1'b0; o_res_val = 1'b0; o_acc_ready = 1'b0;
        o_result_re = '0; o_result_im = '0;
        repeat (3) step();
        checks++; if (res_ready !== 1'b0) $display("FAIL reset_res_ready: got %b expected 0", res_ready); else passed++;
        checks++; if (acc_val !== 1'b0) $display("FAIL reset_acc_val: got %b expected 0", acc_val); else passed++;
        checks++; if (acc_re !== '0 || acc_im !== '0) $display("FAIL reset_acc: got (%0d,%0d) expected (0,0)", sx(acc_re), sx(acc_im)); else passed++;
        checks++; if (acc_sat !== 1'b0) $display("FAIL reset_acc_sat: got %b expected 0", acc_sat); else passed++;
        rstn = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b0) $display("FAIL reset_release_ready: got %b expected 0 before first edge", res_ready); else passed++;
        step();
        checks++; if (res_ready !== 1'b1) $display("FAIL reset_first_edge_ready: got %b expected 1", res_ready); else passed++;
        checks++; if (o_res_ready !== 1'b1) $display("FAIL reset_ovf_ready: got %b expected 1", o_res_ready); else passed++;
    endtask

    task automatic test_basic_frame();
        int w;
        acc_ready = 1'b0;
        model_clear();
        send_beat(1, 2, w);
        send_beat(3, -4, w);
        send_beat(100, 0, w);
        send_beat(-5, 7, w);
        for (int c = 0; c < 3; c++) begin
            checks++; if (acc_val !== 1'b1) $display("FAIL basic_val_hold%0d: got %b expected 1", c, acc_val); else passed++;
            checks++; if (sx(acc_re) !== 99 || sx(acc_im) !== 5) $display("FAIL basic_sum_hold%0d: got (%0d,%0d) expected (99,5)", c, sx(acc_re), sx(acc_im)); else passed++;
            checks++; if (res_ready !== 1'b0) $display("FAIL basic_ready_hold%0d: got %b expected 0", c, res_ready); else passed++;
            if (c < 2) step();
        end
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        checks++; if (acc_val !== 1'b0) $display("FAIL basic_consume_val: got %b expected 0", acc_val); else passed++;
        checks++; if (res_ready !== 1'b1) $display("FAIL basic_consume_ready: got %b expected 1", res_ready); else passed++;
        checks++; if (acc_re !== '0 || acc_im !== '0) $display("FAIL basic_consume_clear: got (%0d,%0d) expected (0,0)", sx(acc_re), sx(acc_im)); else passed++;
    endtask

    task automatic test_bubbles();
        int w;
        acc_ready = 1'b0;
        model_clear();
        for (int b = 0; b < 4; b++) begin
            send_beat(10, -10, w);
            if (b < 3) repeat (2) step();
        end
        checks++; if (acc_val !== 1'b1) $display("FAIL bubbles_val: got %b expected 1", acc_val); else passed++;
        checks++; if (sx(acc_re) !== 40 || sx(acc_im) !== -40) $display("FAIL bubbles_sum: got (%0d,%0d) expected (40,-40)", sx(acc_re), sx(acc_im)); else passed++;
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_sw_rst();
        int w;
        acc_ready = 1'b0;
        model_clear();
        send_beat(50, 50, w);
        send_beat(50, 50, w);
        result_re = (2*DW)'(7); result_im = (2*DW)'(7);
        res_val = 1'b1;
        sw_rst  = 1'b1;
        #1;
        checks++; if (res_ready !== 1'b0) $display("FAIL swrst_ready_during: got %b expected 0", res_ready); else passed++;
        step();
        sw_rst  = 1'b0;
        res_val = 1'b0;
        checks++; if (acc_re !== '0 || acc_im !== '0) $display("FAIL swrst_cleared: got (%0d,%0d) expected (0,0)", sx(acc_re), sx(acc_im)); else passed++;
        checks++; if (res_ready !== 1'b0) $display("FAIL swrst_clear_state_ready: got %b expected 0", res_ready); else passed++;
        model_clear();
        for (int b = 0; b < 4; b++) send_beat(1, 1, w);
        checks++; if (acc_val !== 1'b1) $display("FAIL swrst_val: got %b expected 1", acc_val); else passed++;
        checks++; if (sx(acc_re) !== 4 || sx(acc_im) !== 4) $display("FAIL swrst_sum: got (%0d,%0d) expected (4,4)", sx(acc_re), sx(acc_im)); else passed++;
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int w;
        acc_ready = 1'b1;
        model_clear();
        for (int b = 0; b < 4; b++) send_beat(2, 3, w);
        checks++; if (acc_val !== 1'b1) $display("FAIL b2b_a_val: got %b expected 1", acc_val); else passed++;
        checks++; if (sx(acc_re) !== 8 || sx(acc_im) !== 12) $display("FAIL b2b_a_sum: got (%0d,%0d) expected (8,12)", sx(acc_re), sx(acc_im)); else passed++;
        send_beat(-1, 0, w);
        checks++; if (w !== 1) $display("FAIL b2b_a_hold_cycles: got %0d expected 1", w); else passed++;
        for (int b = 1; b < 4; b++) send_beat(-1, 0, w);
        checks++; if (acc_val !== 1'b1) $display("FAIL b2b_b_val: got %b expected 1", acc_val); else passed++;
        checks++; if (sx(acc_re) !== -4 || sx(acc_im) !== 0) $display("FAIL b2b_b_sum: got (%0d,%0d) expected (-4,0)", sx(acc_re), sx(acc_im)); else passed++;
        step();
        checks++; if (acc_val !== 1'b0 || res_ready !== 1'b1) $display("FAIL b2b_b_hold_cycles: got val=%b ready=%b expected val=0 ready=1", acc_val, res_ready); else passed++;
        acc_ready = 1'b0;
    endtask

    task automatic test_random_frames();
        int w;
        logic [2*DW-1:0] r, i;
        for (int f = 0; f < 25; f++) begin
            acc_ready = 1'b0;
            model_clear();
            for (int b = 0; b < AL; b++) begin
                r = (2*DW)'($urandom);
                i = (2*DW)'($urandom);
                send_beat(int'($signed(r)), int'($signed(i)), w);
                if (b < AL - 1) repeat ($urandom_range(0, 2)) step();
            end
            checks++; if (acc_val !== 1'b1) $display("FAIL rand%0d_val: got %b expected 1", f, acc_val); else passed++;
            checks++; if (sx(acc_re) !== m_re || sx(acc_im) !== m_im) $display("FAIL rand%0d_sum: got (%0d,%0d) expected (%0d,%0d)", f, sx(acc_re), sx(acc_im), m_re, m_im); else passed++;
            checks++; if (acc_sat !== m_sat) $display("FAIL rand%0d_sat: got %b expected %b", f, acc_sat, m_sat); else passed++;
            repeat ($urandom_range(0, 3)) begin
                step();
                checks++; if (acc_val !== 1'b1 || sx(acc_re) !== m_re || sx(acc_im) !== m_im) $display("FAIL rand%0d_hold_stable: got val=%b (%0d,%0d) expected val=1 (%0d,%0d)", f, acc_val, sx(acc_re), sx(acc_im), m_re, m_im); else passed++;
            end
            if ($urandom_range(0, 4) == 0) begin
                sw_rst = 1'b1;
                step();
                sw_rst = 1'b0;
                checks++; if (acc_val !== 1'b0 || acc_re !== '0) $display("FAIL rand%0d_discard: got val=%b re=%0d expected val=0 re=0", f, acc_val, sx(acc_re)); else passed++;
            end else begin
                acc_ready = 1'b1;
                step();
                acc_ready = 1'b0;
                checks++; if (acc_val !== 1'b0 || res_ready !== 1'b1) $display("FAIL rand%0d_consume: got val=%b ready=%b expected val=0 ready=1", f, acc_val, res_ready); else passed++;
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        longint exp_re = SAT_EN ? 32767 : -4;
        longint exp_im = SAT_EN ? -32768 : 0;
        o_acc_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            o_result_re = 16'h7fff;
            o_result_im = 16'h8000;
            o_res_val   = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (o_res_ready) begin ok = 1'b1; step(); break; end
                step();
            end
            o_res_val = 1'b0;
            if (!ok) begin
                checks++;
                $display("FAIL ovf_timeout: beat %0d not accepted within 20 cycles", b);
            end
        end
        checks++; if (o_acc_val !== 1'b1) $display("FAIL ovf_val: got %b expected 1", o_acc_val); else passed++;
        checks++; if (longint'($signed(o_acc_re)) !== exp_re) $display("FAIL ovf_re: got %0d expected %0d", $signed(o_acc_re), exp_re); else passed++;
        checks++; if (longint'($signed(o_acc_im)) !== exp_im) $display("FAIL ovf_im: got %0d expected %0d", $signed(o_acc_im), exp_im); else passed++;
        checks++; if (o_acc_sat !== SAT_EN) $display("FAIL ovf_sat: got %b expected %b", o_acc_sat, SAT_EN); else passed++;
        o_acc_ready = 1'b1;
        step();
        o_acc_ready = 1'b0;
        checks++; if (o_acc_val !== 1'b0 || o_acc_sat !== 1'b0) $display("FAIL ovf_consume: got val=%b sat=%b expected 0 0", o_acc_val, o_acc_sat); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bubbles();
        test_sw_rst();
        test_back_to_back();
        test_random_frames();
        test_overflow();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
